axis_header_insert_strip: RTL and testbench

//  Streaming AXI-Stream header editor, full throughput, MSB-first byte order.
//  Per packet, a header beat is taken first, then one of two modes:
//    - insert: prepend N header bytes to the packet.
//    - strip: delete the first N payload bytes.

---
 rtl/axis_hdr_pkg.sv | 33 +++
 rtl/axis_header_insert_strip_shifter.sv | 26 ++
 rtl/axis_header_insert_strip.sv | 187 ++++++++++++++++++
 tb/tb_axis_header_insert_strip.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header insert/strip block.
// Keep helpers work on wide vectors; callers size-cast to their width.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_e;

  localparam int KMAX = 128;

  // High-aligned keep of k bytes in a w-byte beat.
  function automatic logic [KMAX-1:0] cnt2keep_hi(input int k, input int w);
    logic [KMAX-1:0] m;
    m = '0;
    for (int i = 0; i < KMAX; i++) begin
      if (i < w && i >= w - k) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int keep2cnt(input logic [KMAX-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < KMAX; i++) begin
      c += int'(keep[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_header_insert_strip_shifter.sv
// Byte shifter: packs incoming bytes behind the residue, MSB first.
// Residue bytes past the residue count and masked input bytes must be zero.
module axis_byte_shifter #(
  parameter int DATA_WD = 32,
  parameter int CW      = 3
) (
  input  logic [DATA_WD-1:0] res_i,
  input  logic [CW-1:0]      rcnt_i,
  input  logic [DATA_WD-1:0] data_i,
  input  logic [CW-1:0]      skip_i,
  output logic [DATA_WD-1:0] beat_o,
  output logic [DATA_WD-1:0] rem_o
);

  logic [DATA_WD-1:0]   din_s;
  logic [2*DATA_WD-1:0] comb;

  assign din_s = data_i << {skip_i, 3'b000};

  assign comb = {res_i, {DATA_WD{1'b0}}}
              | ({din_s, {DATA_WD{1'b0}}} >> {rcnt_i, 3'b000});

  assign beat_o = comb[2*DATA_WD-1:DATA_WD];
  assign rem_o  = comb[DATA_WD-1:0];

endmodule

// File: rtl/axis_header_insert_strip.sv
// AXI-Stream header insert/strip with repacking and a registered output.
// A residue register carries bytes that did not fill a whole output beat.
module axis_header_insert_strip
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1,
  parameter int STRIP_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  input  logic                    strip_insert,
  output logic                    ready_insert
);

  localparam int W  = DATA_BYTE_WD;
  localparam int TW = BYTE_CNT_WD + 1;
  localparam logic [TW-1:0] W_T = TW'(W);

  state_e state_q, state_d;

  logic [DATA_WD-1:0]     res_q, res_d;
  logic [DATA_WD-1:0]     dout_q, dout_d;
  logic [DATA_WD-1:0]     din_m, beat, rem, hdr_al;
  logic [BYTE_CNT_WD-1:0] rcnt_q, rcnt_d;
  logic [BYTE_CNT_WD-1:0] skip_q, skip_d;
  logic [BYTE_CNT_WD-1:0] kcnt, ecnt;
  logic [TW-1:0]          total;
  logic [W-1:0]           kout_q, kout_d;
  logic                   vout_q, vout_d;
  logic                   lout_q, lout_d;
  logic                   hdr_hs, in_hs, out_free, strip_m;
  logic                   unused_ins;

  assign unused_ins = ^keep_insert;

  assign valid_out    = vout_q;
  assign data_out     = dout_q;
  assign keep_out     = kout_q;
  assign last_out     = lout_q;
  assign out_free     = ~vout_q | ready_out;
  assign ready_insert = (state_q == IDLE);
  assign ready_in     = (state_q == STREAM) & out_free;
  assign hdr_hs       = valid_insert & ready_insert;
  assign in_hs        = valid_in & ready_in;
  assign strip_m      = (STRIP_EN != 0) & strip_insert;

  // Header bytes sit in the low N bytes; move them to the top.
  assign hdr_al = data_insert << (8 * (W - int'(byte_insert_cnt)));

  always_comb begin
    din_m = '0;
    for (int i = 0; i < W; i++) begin
      if (keep_in[i]) din_m[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  assign kcnt  = BYTE_CNT_WD'(keep2cnt(KMAX'(keep_in)));
  assign ecnt  = (kcnt > skip_q) ? kcnt - skip_q : '0;
  assign total = TW'(rcnt_q) + TW'(ecnt);

  axis_byte_shifter #(
    .DATA_WD (DATA_WD),
    .CW      (BYTE_CNT_WD)
  ) u_shift (
    .res_i   (res_q),
    .rcnt_i  (rcnt_q),
    .data_i  (din_m),
    .skip_i  (skip_q),
    .beat_o  (beat),
    .rem_o   (rem)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    skip_d  = skip_q;
    vout_d  = vout_q & ~ready_out;
    dout_d  = dout_q;
    kout_d  = kout_q;
    lout_d  = lout_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_hs) begin
          state_d = STREAM;
          res_d   = '0;
          rcnt_d  = '0;
          skip_d  = '0;
          if (strip_m) begin
            skip_d = byte_insert_cnt;
          end else if (TW'(byte_insert_cnt) == W_T) begin
            vout_d = 1'b1;
            dout_d = data_insert;
            kout_d = '1;
            lout_d = 1'b0;
          end else begin
            res_d  = hdr_al;
            rcnt_d = byte_insert_cnt;
          end
        end
      end
      STREAM: begin
        if (in_hs) begin
          skip_d = '0;
          if (total >= W_T) begin
            vout_d = 1'b1;
            dout_d = beat;
            kout_d = '1;
            lout_d = last_in & (total == W_T);
            res_d  = rem;
            rcnt_d = BYTE_CNT_WD'(total - W_T);
            if (last_in) state_d = (total == W_T) ? DONE : FLUSH;
          end else if (last_in) begin
            res_d  = '0;
            rcnt_d = '0;
            if (total != '0) begin
              vout_d  = 1'b1;
              dout_d  = beat;
              kout_d  = W'(cnt2keep_hi(int'(total), W));
              lout_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            res_d  = beat;
            rcnt_d = BYTE_CNT_WD'(total);
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          vout_d  = 1'b1;
          dout_d  = res_q;
          kout_d  = W'(cnt2keep_hi(int'(rcnt_q), W));
          lout_d  = 1'b1;
          res_d   = '0;
          rcnt_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (vout_q & ready_out & lout_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      rcnt_q  <= '0;
      skip_q  <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      skip_q  <= skip_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      lout_q  <= lout_d;
    end
  end

endmodule

// File: tb/tb_axis_header_insert_strip.sv
// Scoreboard bench for axis_header_insert_strip (W=4).
// Expected beats come from a byte-list model of the packet edit.
module tb_axis_header_insert_strip;

  localparam int W  = 4;
  localparam int DW = 32;
  localparam int CW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [W-1:0]  keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [W-1:0]  keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_insert;
  logic [DW-1:0] data_insert;
  logic [W-1:0]  keep_insert;
  logic [CW-1:0] byte_insert_cnt;
  logic          strip_insert;
  logic          ready_insert;

  always #5 clk = ~clk;

  axis_header_insert_strip dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .strip_insert    (strip_insert),
    .ready_insert    (ready_insert)
  );

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Downstream ready: 0 always, 1 toggle, 2 random
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = ~ready_out;
        default: ready_out = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: pops on each output handshake, checks stall stability
  initial begin
    logic          stall;
    beat_t         hold;
    beat_t         e;
    logic [DW-1:0] m;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall)
          chk("hold", {valid_out, data_out, keep_out, last_out},
              {1'b1, hold});
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h/%0h/%0b expected none",
                     data_out, keep_out, last_out);
          end else begin
            e = exp_q.pop_front();
            m = '0;
            for (int j = 0; j < W; j++)
              if (e.k[j]) m[8*j +: 8] = 8'hFF;
            chk("beat", {data_out & m, keep_out, last_out}, e);
          end
        end
        stall = valid_out & ~ready_out;
        hold  = {data_out, keep_out, last_out};
      end
    end
  end

  task automatic model(input logic s, input int n, input logic [DW-1:0] h,
                       input logic [7:0] pl[$]);
    logic [7:0] ob[$];
    beat_t      b;
    int         c;
    if (!s)
      for (int i = n - 1; i >= 0; i--) ob.push_back(h[8*i +: 8]);
    for (int i = (s ? n : 0); i < pl.size(); i++) ob.push_back(pl[i]);
    while (ob.size() > 0) begin
      b = '0;
      c = (ob.size() < W) ? ob.size() : W;
      for (int j = 0; j < c; j++) begin
        b.d[8*(W-1-j) +: 8] = ob.pop_front();
        b.k[W-1-j] = 1'b1;
      end
      b.l = (ob.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_header(input logic s, input int n,
                           input logic [DW-1:0] h);
    int t;
    valid_insert    = 1'b1;
    strip_insert    = s;
    byte_insert_cnt = CW'(n);
    data_insert     = h;
    keep_insert     = W'((1 << n) - 1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_insert && t < 200);
    if (!ready_insert) begin
      chk("hdr_timeout", 0, 1);
      valid_insert = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_insert    = 1'b0;
    data_insert     = $urandom;
    byte_insert_cnt = CW'($urandom_range(0, 4));
    strip_insert    = 1'($urandom % 2);
  endtask

  task automatic do_beat(input logic [DW-1:0] d, input logic [W-1:0] k,
                         input logic l, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_in && t < 200);
    if (!ready_in) begin
      chk("beat_timeout", 0, 1);
      valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = $urandom;
    last_in  = 1'($urandom % 2);
  endtask

  task automatic send_beats(input logic [7:0] pl[$], input int gmax);
    int            nb;
    int            idx;
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    nb = (pl.size() + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      d = $urandom;
      k = '0;
      for (int j = 0; j < W; j++) begin
        idx = b * W + j;
        if (idx < pl.size()) begin
          d[8*(W-1-j) +: 8] = pl[idx];
          k[W-1-j] = 1'b1;
        end
      end
      do_beat(d, k, b == nb - 1, $urandom_range(0, gmax));
    end
  endtask

  task automatic send_packet(input logic s, input int n,
                             input logic [DW-1:0] h,
                             input logic [7:0] pl[$], input int gmax);
    model(s, n, h, pl);
    do_header(s, n, h);
    send_beats(pl, gmax);
  endtask

  initial begin
    logic [7:0] p6[$];
    logic [7:0] p7[$];
    logic [7:0] pr[$];
    int         t;
    int         len;
    int         n;
    logic       s;

    p6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    p7 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    rst_n = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
    byte_insert_cnt = '0; strip_insert = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_keep_out", keep_out, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_ready_insert", ready_insert, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Insert N=2 and N=3 (the latter needs a flush beat)
    send_packet(1'b0, 2, 32'h0000AABB, p6, 0);
    send_packet(1'b0, 3, 32'h00CCDDEE, p7, 0);

    // Same with toggling backpressure
    ready_mode = 1;
    send_packet(1'b0, 3, 32'h00CCDDEE, p7, 0);
    ready_mode = 0;

    // Strip N=1
    send_packet(1'b1, 1, 32'h0, p6, 0);

    // Insert N=W: header beat leaves 1 cycle after the header handshake
    model(1'b0, 4, 32'hA1B2C3D4, '{8'h11});
    do_header(1'b0, 4, 32'hA1B2C3D4);
    chk("hdr_beat_latency", valid_out, 1);
    send_beats('{8'h11}, 0);

    // N=0 pass-through, both modes
    send_packet(1'b0, 0, 32'hDEADBEEF, p7, 0);
    send_packet(1'b1, 0, 32'hDEADBEEF, p6, 0);

    // Strip consumes the whole packet
    send_packet(1'b1, 4, 32'h0, '{8'h11, 8'h22, 8'h33, 8'h44}, 0);
    chk("strip_all_idle", {valid_out, ready_insert}, 2'b01);
    send_packet(1'b1, 3, 32'h0, '{8'h99, 8'h88}, 0);
    chk("strip_short_idle", {valid_out, ready_insert}, 2'b01);

    // Reset in the middle of a packet
    model(1'b0, 3, 32'h00CCDDEE, p7);
    do_header(1'b0, 3, 32'h00CCDDEE);
    do_beat(32'h11223344, 4'b1111, 1'b0, 0);
    do_beat(32'h55667700, 4'b1110, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_ready", {ready_in, ready_insert}, 2'b01);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_packet(1'b0, 2, 32'h0000AABB, p6, 0);

    // Randomized packets
    for (int r = 0; r < 40; r++) begin
      ready_mode = $urandom_range(0, 2);
      s   = 1'($urandom % 2);
      n   = $urandom_range(0, 4);
      len = $urandom_range(1, 12);
      pr.delete();
      for (int i = 0; i < len; i++) pr.push_back(8'($urandom));
      send_packet(s, n, $urandom, pr, 1);
    end

    ready_mode = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_idle", {valid_out, ready_insert}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
